// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and data access.
// Define ARB_STARVE_GUARD_EN to let a starved fetch win after STARVE_LIMIT data grants.
module unified_mem_arbiter #(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             IReq,
  input  logic [WIDTH-1:0] IAddr,
  output logic [WIDTH-1:0] IRdata,
  output logic             IReady,
  input  logic             DReq,
  input  logic             DWe,
  input  logic [WIDTH-1:0] DAddr,
  input  logic [WIDTH-1:0] DWdata,
  output logic [WIDTH-1:0] DRdata,
  output logic             DReady,
  output logic             MemReq,
  output logic             MemWe,
  output logic [WIDTH-1:0] MemAddr,
  output logic [WIDTH-1:0] MemWdata,
  input  logic [WIDTH-1:0] MemRdata,
  input  logic             MemAck,
  output logic             StallF,
  output logic             StallM
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  localparam logic [WIDTH-1:0] ADDR_MASK = ~WIDTH'(3);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] addr_reg, wdata_reg, irdata_reg, drdata_reg;
  logic             we_reg, iready_reg, dready_reg;
  logic             starve_hit, pick_i, grant_i, grant_d;

  // Fetch wins only when data is idle, or when the starvation guard has tripped.
  assign pick_i  = IReq && (!DReq || starve_hit);
  assign grant_i = (state_reg == IDLE) && (state_next == IBUSY);
  assign grant_d = (state_reg == IDLE) && (state_next == DBUSY);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        // The Ready cycle is a dead cycle: no new grant while a pulse is out.
        if (!(iready_reg || dready_reg)) begin
          if (pick_i)    state_next = IBUSY;
          else if (DReq) state_next = DBUSY;
        end
      end
      IBUSY, DBUSY: begin
        if (MemAck) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      we_reg     <= 1'b0;
      irdata_reg <= '0;
      drdata_reg <= '0;
      iready_reg <= 1'b0;
      dready_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      iready_reg <= (state_reg == IBUSY) && MemAck;
      dready_reg <= (state_reg == DBUSY) && MemAck;
      if (grant_i) begin
        addr_reg <= IAddr & ADDR_MASK;
        we_reg   <= 1'b0;
      end else if (grant_d) begin
        addr_reg  <= DAddr & ADDR_MASK;
        we_reg    <= DWe;
        wdata_reg <= DWdata;
      end
      if ((state_reg == IBUSY) && MemAck) irdata_reg <= MemRdata;
      if ((state_reg == DBUSY) && MemAck && !we_reg) drdata_reg <= MemRdata;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_reg;

  assign starve_hit = (starve_reg >= LIMIT);

  // Counts data grants taken over a waiting fetch; saturates at the limit.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      starve_reg <= '0;
    end else if (grant_i) begin
      starve_reg <= '0;
    end else if (grant_d && IReq && (starve_reg < LIMIT)) begin
      starve_reg <= starve_reg + CW'(1);
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  assign IRdata   = irdata_reg;
  assign DRdata   = drdata_reg;
  assign IReady   = iready_reg;
  assign DReady   = dready_reg;
  assign MemReq   = (state_reg != IDLE);
  assign MemWe    = (state_reg == DBUSY) && we_reg;
  assign MemAddr  = addr_reg;
  assign MemWdata = wdata_reg;
  assign StallF   = IReq & ~iready_reg;
  assign StallM   = DReq & ~dready_reg;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a latency-programmable memory model.
// Starvation expectations follow ARB_STARVE_GUARD_EN as seen by this compile.
module tb_unified_mem_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        IReq, DReq, DWe;
  logic [31:0] IAddr, DAddr, DWdata;
  logic [31:0] IRdata, DRdata, MemAddr, MemWdata, MemRdata;
  logic        IReady, DReady, MemReq, MemWe, MemAck, StallF, StallM;

  int total = 0;
  int bad   = 0;
  int mem_lat = 1;
  int mem_cnt = 0;
  bit stray_ack = 1'b0;

  always #5 Clk = ~Clk;

  unified_mem_arbiter #(.WIDTH(32), .STARVE_LIMIT(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .IReq(IReq), .IAddr(IAddr), .IRdata(IRdata), .IReady(IReady),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata),
    .DRdata(DRdata), .DReady(DReady),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemRdata(MemRdata), .MemAck(MemAck),
    .StallF(StallF), .StallM(StallM)
  );

  // Memory: acks in the mem_lat-th cycle of MemReq, returning address ^ 0x5A5A0000.
  initial begin
    MemAck   = 1'b0;
    MemRdata = '0;
    forever begin
      @(posedge Clk);
      #1;
      if (stray_ack) begin
        MemAck   = 1'b1;
        MemRdata = 32'h1234_5678;
      end else if (!MemReq || MemAck) begin
        MemAck  = 1'b0;
        mem_cnt = 0;
      end else begin
        mem_cnt++;
        if (mem_cnt == mem_lat) begin
          MemAck   = 1'b1;
          MemRdata = MemAddr ^ 32'h5A5A_0000;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for IReady or DReady, noting the first MemReq cycle's outputs.
  task automatic wait_done(input bit want_d, input string tag, output int mreq_n,
                           output logic [31:0] a0, output logic w0, output logic [31:0] wd0);
    bit done = 1'b0;
    mreq_n = 0;
    a0 = '0;
    w0 = 1'b0;
    wd0 = '0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge Clk);
      if (MemReq) begin
        if (mreq_n == 0) begin
          a0  = MemAddr;
          w0  = MemWe;
          wd0 = MemWdata;
        end
        mreq_n++;
      end
      if (want_d ? DReady : IReady) done = 1'b1;
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    $display("txn %s port=%s addr=%h we=%0b memreq_cycles=%0d", tag, want_d ? "D" : "I",
             a0, w0, mreq_n);
  endtask

  int          n;
  logic [31:0] a0, wd0;
  logic        w0;
  int          gnt_n, first_i;
  logic        prev_req;
  int          exp_first_i;

  initial begin
    Reset_n = 1'b0;
    IReq = 1'b0; IAddr = '0;
    DReq = 1'b0; DWe = 1'b0; DAddr = '0; DWdata = '0;
    repeat (2) @(negedge Clk);
    check("rst_memreq", {31'd0, MemReq}, 32'd0);
    check("rst_memwe", {31'd0, MemWe}, 32'd0);
    check("rst_iready", {31'd0, IReady}, 32'd0);
    check("rst_dready", {31'd0, DReady}, 32'd0);
    check("rst_irdata", IRdata, 32'd0);
    check("rst_drdata", DRdata, 32'd0);
    check("rst_memaddr", MemAddr, 32'd0);
    check("rst_memwdata", MemWdata, 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Single fetch with low address bits set
    mem_lat = 1;
    IReq = 1'b1; IAddr = 32'h0000_0013;
    #1 check("f_stallf_on", {31'd0, StallF}, 32'd1);
    wait_done(1'b0, "fetch", n, a0, w0, wd0);
    check("f_addr", a0, 32'h0000_0010);
    check("f_memreq_cycles", n, 32'd1);
    check("f_irdata", IRdata, 32'h5A5A_0010);
    check("f_stallf_off", {31'd0, StallF}, 32'd0);
    IReq = 1'b0;
    @(negedge Clk);
    check("f_iready_pulse", {31'd0, IReady}, 32'd0);
    check("f_irdata_hold", IRdata, 32'h5A5A_0010);

    // Simultaneous requests: data first, fetch only after a dead cycle
    mem_lat = 2;
    IReq = 1'b1; IAddr = 32'h0000_0100;
    DReq = 1'b1; DWe = 1'b0; DAddr = 32'h0000_0040;
    wait_done(1'b1, "both_d", n, a0, w0, wd0);
    check("b_first_addr", a0, 32'h0000_0040);
    check("b_drdata", DRdata, 32'h5A5A_0040);
    check("b_stallm_off", {31'd0, StallM}, 32'd0);
    check("b_stallf_on", {31'd0, StallF}, 32'd1);
    DReq = 1'b0;
    @(negedge Clk);
    check("b_no_grant_after_ready", {31'd0, MemReq}, 32'd0);
    wait_done(1'b0, "both_i", n, a0, w0, wd0);
    check("b_i_addr", a0, 32'h0000_0100);
    check("b_irdata", IRdata, 32'h5A5A_0100);
    IReq = 1'b0;
    @(negedge Clk);

    // Store leaves DRdata untouched
    mem_lat = 3;
    DReq = 1'b1; DWe = 1'b1; DAddr = 32'h0000_0008; DWdata = 32'hDEAD_BEEF;
    wait_done(1'b1, "store", n, a0, w0, wd0);
    check("s_addr", a0, 32'h0000_0008);
    check("s_memwe", {31'd0, w0}, 32'd1);
    check("s_memwdata", wd0, 32'hDEAD_BEEF);
    check("s_drdata_hold", DRdata, 32'h5A5A_0040);
    DReq = 1'b0; DWe = 1'b0;
    @(negedge Clk);
    check("s_memwe_idle", {31'd0, MemWe}, 32'd0);

    // Stray MemAck while idle is ignored
    stray_ack = 1'b1;
    @(negedge Clk);
    stray_ack = 1'b0;
    @(negedge Clk);
    check("x_iready", {31'd0, IReady}, 32'd0);
    check("x_dready", {31'd0, DReady}, 32'd0);
    check("x_irdata", IRdata, 32'h5A5A_0100);
    check("x_memreq", {31'd0, MemReq}, 32'd0);

    // Reset in the middle of a long load
    mem_lat = 5;
    DReq = 1'b1; DWe = 1'b0; DAddr = 32'h0000_0020;
    repeat (2) @(negedge Clk);
    check("r_pre_memreq", {31'd0, MemReq}, 32'd1);
    Reset_n = 1'b0;
    IReq = 1'b1; IAddr = 32'h0000_0200; DAddr = 32'h0000_0024;
    #1;
    check("r_memreq_now", {31'd0, MemReq}, 32'd0);
    check("r_drdata", DRdata, 32'd0);
    check("r_irdata", IRdata, 32'd0);
    @(negedge Clk);
    check("r_no_dready", {31'd0, DReady}, 32'd0);
    Reset_n = 1'b1;
    wait_done(1'b1, "post_rst_d", n, a0, w0, wd0);
    check("r_next_is_data", a0, 32'h0000_0024);
    check("r_drdata_new", DRdata, 32'h5A5A_0024);
    DReq = 1'b0;
    wait_done(1'b0, "post_rst_i", n, a0, w0, wd0);
    check("r_i_addr", a0, 32'h0000_0200);
    check("r_irdata_new", IRdata, 32'h5A5A_0200);
    IReq = 1'b0;
    @(negedge Clk);

    // Data held with fetch waiting
    mem_lat = 1;
    IReq = 1'b1; IAddr = 32'h0000_0300;
    DReq = 1'b1; DWe = 1'b0; DAddr = 32'h0000_0050;
    gnt_n = 0;
    first_i = 0;
    prev_req = 1'b0;
    for (int c = 0; c < 60 && gnt_n < 6; c++) begin
      @(negedge Clk);
      if (MemReq && !prev_req) begin
        gnt_n++;
        if (MemAddr == 32'h0000_0300 && first_i == 0) first_i = gnt_n;
        $display("txn starve grant=%0d addr=%h", gnt_n, MemAddr);
      end
      prev_req = MemReq;
    end
`ifdef ARB_STARVE_GUARD_EN
    exp_first_i = 5;
`else
    exp_first_i = 0;
`endif
    check("sv_grants", gnt_n, 32'd6);
    check("sv_first_i_grant", first_i, exp_first_i);
    IReq = 1'b0; DReq = 1'b0;
    for (int c = 0; c < 20 && MemReq; c++) @(negedge Clk);
    repeat (2) @(negedge Clk);
    check("sv_drained", {31'd0, MemReq}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
